// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the per-axis region type
// for the snake display timing generator.
package vga_pkg;

    localparam int VGA_CLK_DIV    = 4;
    localparam int VGA_H_ACTIVE   = 640;
    localparam int VGA_H_FP       = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BP       = 48;
    localparam int VGA_V_ACTIVE   = 480;
    localparam int VGA_V_FP       = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BP       = 33;
    localparam int VGA_SYNC_POL   = 0;
    localparam int VGA_SYNC_DELAY = 1;
    localparam int VGA_CNT_W      = 10;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } region_e;

    function automatic int axis_total(input int active_len, input int fp_len,
                                      input int sync_len, input int bp_len);
        return active_len + fp_len + sync_len + bp_len;
    endfunction

    function automatic int h_total();
        return axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    endfunction

    function automatic int v_total();
        return axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: position, data enable, syncs, strobe and pacing ticks.
interface vga_timing_gen_if;

    logic       pix_stb;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic       line_tick;
    logic       frame_tick;

    modport master (
        output pix_stb, x, y, de, hsync, vsync, line_tick, frame_tick
    );

    modport slave (
        input pix_stb, x, y, de, hsync, vsync, line_tick, frame_tick
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its ACTIVE/FRONT/SYNC/BACK
// region FSM. active_nxt/sync_nxt describe the state the axis is about to enter.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACT_LEN  = 640,
    parameter int FP_LEN   = 16,
    parameter int SYNC_LEN = 96,
    parameter int BP_LEN   = 48,
    parameter int W        = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         active_nxt,
    output logic         sync_nxt,
    output logic         wrap
);

    localparam int           TOTAL = axis_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);
    localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
    localparam logic [W-1:0] ZERO  = {W{1'b0}};
    localparam logic [W-1:0] ONE   = W'(1'b1);

    logic [W-1:0] count_r;
    logic [W-1:0] count_nxt_s;
    region_e      state_r;
    region_e      state_nxt_s;

    function automatic region_e region_of(input logic [W-1:0] c);
        region_e r;
        if (int'(c) < ACT_LEN) begin
            r = ACTIVE;
        end else if (int'(c) < ACT_LEN + FP_LEN) begin
            r = FRONT;
        end else if (int'(c) < ACT_LEN + FP_LEN + SYNC_LEN) begin
            r = SYNC;
        end else begin
            r = BACK;
        end
        return r;
    endfunction

    assign wrap = (count_r == LAST);

    // Next count and region; deriving the region from the new count lets an
    // empty region fall through within the same strobe.
    always_comb begin
        count_nxt_s = count_r;
        state_nxt_s = state_r;
        if (en) begin
            if (wrap) begin
                count_nxt_s = ZERO;
            end else begin
                count_nxt_s = count_r + ONE;
            end
            state_nxt_s = region_of(count_nxt_s);
        end else begin
            count_nxt_s = count_r;
            state_nxt_s = state_r;
        end
    end

    // Count and region state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO;
            state_r <= ACTIVE;
        end else begin
            count_r <= count_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    assign count      = count_r;
    assign active_nxt = (state_nxt_s == ACTIVE);
    assign sync_nxt   = (state_nxt_s == SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe divider, horizontal/vertical axis counters,
// registered data enable, delayed syncs and line/frame pacing ticks.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = VGA_CLK_DIV,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int SYNC_POL   = VGA_SYNC_POL,
    parameter int SYNC_DELAY = VGA_SYNC_DELAY
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int               DIV_W      = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1'b1);
    localparam logic             SYNC_ON    = (SYNC_POL != 0);
    localparam logic             SYNC_IDLE  = (SYNC_POL == 0);
    localparam logic [9:0]       V_LAST_ACT = 10'(V_ACTIVE - 1);

    logic [DIV_W-1:0]  div_r;
    logic              pix_stb_r;
    logic [9:0]        x_s;
    logic [9:0]        y_s;
    logic              h_wrap_s;
    logic              v_en_s;
    logic              h_active_nxt_s;
    logic              v_active_nxt_s;
    logic              h_sync_nxt_s;
    logic              v_sync_nxt_s;
    logic              v_wrap_unused_s;
    logic              de_r;
    logic              line_tick_r;
    logic              frame_tick_r;
    logic [SYNC_DELAY:0] hs_pipe_r;
    logic [SYNC_DELAY:0] vs_pipe_r;

    // Pixel-rate divider; the strobe is registered on the wrapping clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r     <= DIV_ZERO;
            pix_stb_r <= 1'b0;
        end else if (div_r == DIV_LAST) begin
            div_r     <= DIV_ZERO;
            pix_stb_r <= 1'b1;
        end else begin
            div_r     <= div_r + DIV_ONE;
            pix_stb_r <= 1'b0;
        end
    end

    assign v_en_s = pix_stb_r & h_wrap_s;

    vga_axis_counter #(
        .ACT_LEN (H_ACTIVE),
        .FP_LEN  (H_FP),
        .SYNC_LEN(H_SYNC),
        .BP_LEN  (H_BP),
        .W       (10)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .en        (pix_stb_r),
        .count     (x_s),
        .active_nxt(h_active_nxt_s),
        .sync_nxt  (h_sync_nxt_s),
        .wrap      (h_wrap_s)
    );

    vga_axis_counter #(
        .ACT_LEN (V_ACTIVE),
        .FP_LEN  (V_FP),
        .SYNC_LEN(V_SYNC),
        .BP_LEN  (V_BP),
        .W       (10)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .en        (v_en_s),
        .count     (y_s),
        .active_nxt(v_active_nxt_s),
        .sync_nxt  (v_sync_nxt_s),
        .wrap      (v_wrap_unused_s)
    );

    // de, ticks and sync delay line; stage 0 is aligned with x/y
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_r         <= 1'b0;
            line_tick_r  <= 1'b0;
            frame_tick_r <= 1'b0;
            hs_pipe_r    <= {(SYNC_DELAY + 1){SYNC_IDLE}};
            vs_pipe_r    <= {(SYNC_DELAY + 1){SYNC_IDLE}};
        end else begin
            line_tick_r  <= v_en_s;
            frame_tick_r <= v_en_s & (y_s == V_LAST_ACT);
            if (pix_stb_r) begin
                de_r         <= h_active_nxt_s & v_active_nxt_s;
                hs_pipe_r[0] <= h_sync_nxt_s ? SYNC_ON : SYNC_IDLE;
                vs_pipe_r[0] <= v_sync_nxt_s ? SYNC_ON : SYNC_IDLE;
            end
            for (int i = SYNC_DELAY; i > 0; i--) begin
                hs_pipe_r[i] <= hs_pipe_r[i-1];
                vs_pipe_r[i] <= vs_pipe_r[i-1];
            end
        end
    end

    assign vga.pix_stb    = pix_stb_r;
    assign vga.x          = x_s;
    assign vga.y          = y_s;
    assign vga.de         = de_r;
    assign vga.hsync      = hs_pipe_r[SYNC_DELAY];
    assign vga.vsync      = vs_pipe_r[SYNC_DELAY];
    assign vga.line_tick  = line_tick_r;
    assign vga.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance, a SYNC_DELAY=3 twin, and a tiny
// raster (7x4, CLK_DIV=2, V_FP=0) checked against closed-form expectations.
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    vga_timing_gen_if if_d();
    vga_timing_gen_if if_d3();
    vga_timing_gen_if if_s();

    vga_timing_gen dut_d (.clk(clk), .rst(rst), .vga(if_d));

    vga_timing_gen #(.SYNC_DELAY(3)) dut_d3 (.clk(clk), .rst(rst), .vga(if_d3));

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0), .SYNC_DELAY(1)
    ) dut_s (.clk(clk), .rst(rst), .vga(if_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected tiny-raster outputs n clocks after reset release
    // (H_TOTAL=7, hsync at x=5; V_TOTAL=4, vsync at y=2; frame = 28 strobes).
    function automatic logic [25:0] small_exp(input int n);
        int p, q, pos, qpos;
        logic [9:0] ex, ey;
        logic ede, ehs, evs, estb, elt, eft;
        p    = (n >= 1) ? (n - 1) / 2 : 0;
        q    = (n >= 2) ? (n - 2) / 2 : 0;
        pos  = p % 28;
        qpos = q % 28;
        ex   = 10'(pos % 7);
        ey   = 10'(pos / 7);
        ede  = (p > 0) && (pos % 7 < 4) && (pos / 7 < 2);
        ehs  = !(qpos % 7 == 5);
        evs  = !(qpos / 7 == 2);
        estb = (n >= 2) && (n % 2 == 0);
        elt  = (n >= 3) && (n % 2 == 1) && (pos % 7 == 0);
        eft  = elt && (pos / 7 == 2);
        return {ex, ey, ede, ehs, evs, estb, elt, eft};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [25:0] want;
        logic [10:0] got_sx;
        logic [10:0] want_sx;
        want = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({if_d.x, if_d.y, if_d.de, if_d.hsync, if_d.vsync, if_d.pix_stb,
             if_d.line_tick, if_d.frame_tick} !== want) begin
            miscompares++;
            $display("FAIL reset_default: got %h want %h", {if_d.x, if_d.y, if_d.de,
                     if_d.hsync, if_d.vsync, if_d.pix_stb, if_d.line_tick, if_d.frame_tick}, want);
        end
        vectors++;
        if ({if_d3.x, if_d3.y, if_d3.de, if_d3.hsync, if_d3.vsync, if_d3.pix_stb,
             if_d3.line_tick, if_d3.frame_tick} !== want) begin
            miscompares++;
            $display("FAIL reset_delay3: got %h want %h", {if_d3.x, if_d3.y, if_d3.de,
                     if_d3.hsync, if_d3.vsync, if_d3.pix_stb, if_d3.line_tick, if_d3.frame_tick}, want);
        end
        vectors++;
        if ({if_s.x, if_s.y, if_s.de, if_s.hsync, if_s.vsync, if_s.pix_stb,
             if_s.line_tick, if_s.frame_tick} !== want) begin
            miscompares++;
            $display("FAIL reset_small: got %h want %h", {if_s.x, if_s.y, if_s.de,
                     if_s.hsync, if_s.vsync, if_s.pix_stb, if_s.line_tick, if_s.frame_tick}, want);
        end
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            want_sx = {(n % 4 == 0) ? 1'b1 : 1'b0, 10'((n - 1) / 4)};
            got_sx  = {if_d.pix_stb, if_d.x};
            vectors++;
            if (got_sx !== want_sx) begin
                miscompares++;
                $display("FAIL strobe_clk%0d: got stb/x %h want %h", n, got_sx, want_sx);
            end
        end
    endtask

    task automatic test_horizontal();
        int de_cnt, hs_cnt, lt_cnt, first_hs_x, lt_x;
        logic [9:0] want_x;
        de_cnt = 0; hs_cnt = 0; lt_cnt = 0; first_hs_x = -1; lt_x = -1;
        apply_reset();
        repeat (6) @(negedge clk);
        for (int k = 0; k < 800; k++) begin
            want_x = 10'((1 + k) % 800);
            vectors++;
            if (if_d.x !== want_x) begin
                miscompares++;
                $display("FAIL hline_x_%0d: got %0d want %0d", k, if_d.x, want_x);
            end
            if (if_d.de === 1'b1) de_cnt++;
            if (if_d.hsync === 1'b0) begin
                hs_cnt++;
                if (first_hs_x < 0) first_hs_x = int'(if_d.x);
            end
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (if_d.line_tick === 1'b1) begin
                    lt_cnt++;
                    lt_x = int'(if_d.x);
                end
            end
        end
        vectors++;
        if (de_cnt != 640) begin miscompares++; $display("FAIL hline_de_count: got %0d want 640", de_cnt); end
        vectors++;
        if (hs_cnt != 96) begin miscompares++; $display("FAIL hline_hsync_count: got %0d want 96", hs_cnt); end
        vectors++;
        if (first_hs_x != 656) begin miscompares++; $display("FAIL hline_hsync_start: got %0d want 656", first_hs_x); end
        vectors++;
        if (lt_cnt != 1) begin miscompares++; $display("FAIL hline_tick_count: got %0d want 1", lt_cnt); end
        vectors++;
        if (lt_x != 0) begin miscompares++; $display("FAIL hline_tick_x: got %0d want 0", lt_x); end
        vectors++;
        if (if_d.y !== 10'd1) begin miscompares++; $display("FAIL hline_y_step: got %0d want 1", if_d.y); end
    endtask

    task automatic test_sync_align();
        int nx, nh1, nh3;
        nx = -1; nh1 = -1; nh3 = -1;
        apply_reset();
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (nx < 0 && if_d.x === 10'd656) nx = n;
            if (nh1 < 0 && if_d.hsync === 1'b0) nh1 = n;
            if (nh3 < 0 && if_d3.hsync === 1'b0) nh3 = n;
        end
        vectors++;
        if (nx != 2625) begin miscompares++; $display("FAIL align_x656_clk: got %0d want 2625", nx); end
        vectors++;
        if (nh1 - nx != 1 || nh1 < 0) begin
            miscompares++; $display("FAIL align_delay1: got %0d want 1", nh1 - nx);
        end
        vectors++;
        if (nh3 - nx != 3 || nh3 < 0) begin
            miscompares++; $display("FAIL align_delay3: got %0d want 3", nh3 - nx);
        end
    endtask

    task automatic test_small_sequence();
        logic [25:0] got, want;
        apply_reset();
        for (int n = 0; n <= 120; n++) begin
            if (n > 0) @(negedge clk);
            want = small_exp(n);
            got  = {if_s.x, if_s.y, if_s.de, if_s.hsync, if_s.vsync, if_s.pix_stb,
                    if_s.line_tick, if_s.frame_tick};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL small_seq_clk%0d: got %h want %h", n, got, want);
            end
        end
    endtask

    task automatic test_small_frame();
        int de_cnt, vs_cnt, hs_cnt, ft_cnt, ft_x, ft_y;
        de_cnt = 0; vs_cnt = 0; hs_cnt = 0; ft_cnt = 0; ft_x = -1; ft_y = -1;
        apply_reset();
        for (int n = 1; n <= 58; n++) begin
            @(negedge clk);
            if (n >= 4 && n % 2 == 0) begin
                if (if_s.de === 1'b1) de_cnt++;
                if (if_s.vsync === 1'b0) vs_cnt++;
                if (if_s.hsync === 1'b0) hs_cnt++;
            end
            if (if_s.frame_tick === 1'b1) begin
                ft_cnt++;
                ft_x = int'(if_s.x);
                ft_y = int'(if_s.y);
            end
        end
        vectors++;
        if (de_cnt != 8) begin miscompares++; $display("FAIL frame_de_count: got %0d want 8", de_cnt); end
        vectors++;
        if (vs_cnt != 7) begin miscompares++; $display("FAIL frame_vsync_count: got %0d want 7", vs_cnt); end
        vectors++;
        if (hs_cnt != 4) begin miscompares++; $display("FAIL frame_hsync_count: got %0d want 4", hs_cnt); end
        vectors++;
        if (ft_cnt != 1) begin miscompares++; $display("FAIL frame_tick_count: got %0d want 1", ft_cnt); end
        vectors++;
        if (ft_x != 0 || ft_y != 2) begin
            miscompares++; $display("FAIL frame_tick_pos: got (%0d,%0d) want (0,2)", ft_x, ft_y);
        end
    endtask

    task automatic test_mid_reset();
        logic [25:0] got, want;
        apply_reset();
        repeat (36) @(negedge clk);
        want = small_exp(36);
        got  = {if_s.x, if_s.y, if_s.de, if_s.hsync, if_s.vsync, if_s.pix_stb,
                if_s.line_tick, if_s.frame_tick};
        vectors++;
        if (got !== want) begin
            miscompares++; $display("FAIL midrst_before: got %h want %h", got, want);
        end
        #2 rst = 1'b1;
        #1;
        want = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        got  = {if_s.x, if_s.y, if_s.de, if_s.hsync, if_s.vsync, if_s.pix_stb,
                if_s.line_tick, if_s.frame_tick};
        vectors++;
        if (got !== want) begin
            miscompares++; $display("FAIL midrst_async: got %h want %h", got, want);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n <= 70; n++) begin
            if (n > 0) @(negedge clk);
            want = small_exp(n);
            got  = {if_s.x, if_s.y, if_s.de, if_s.hsync, if_s.vsync, if_s.pix_stb,
                    if_s.line_tick, if_s.frame_tick};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL midrst_restart_clk%0d: got %h want %h", n, got, want);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        test_reset();
        test_horizontal();
        test_sync_align();
        test_small_sequence();
        test_small_frame();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates raster timing for the snake display. It divides the system clock to a pixel strobe and runs horizontal and vertical position counters, each with an FSM over its regions. It drives x, y and de to the pixel renderer, and drives hsync/vsync to the VGA connector. hsync/vsync are delayed so they stay aligned with the renderer's one-clock registered rgb; it also emits line and frame ticks for game-logic pacing.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
SYNC_DELAY, 1, clk cycles of delay applied to hsync/vsync relative to x/y/de

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pix_stb  out  1  one-clk pulse every CLK_DIV clocks; x/y/de update on the clock after it
x  out  10  horizontal counter, 0..H_TOTAL-1
y  out  10  vertical counter, 0..V_TOTAL-1
de  out  1  high iff x < H_ACTIVE and y < V_ACTIVE
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
line_tick  out  1  one-clk pulse when x wraps to 0
frame_tick  out  1  one-clk pulse when y enters V_ACTIVE (start of vertical blanking)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be <= 1024.
- Reset (async, active-high, all state):
  - Divider = 0; x = 0; y = 0.
  - de = 0, pix_stb = 0, line_tick = 0, frame_tick = 0.
  - hsync and vsync = ~SYNC_POL, and the whole delay line is filled with ~SYNC_POL.
- Divider:
  - Counts 0..CLK_DIV-1; pix_stb is registered high on the clock where the divider wraps.
  - First pix_stb is on the CLK_DIV-th rising edge after rst deasserts.
- Horizontal counter:
  - On each clk with pix_stb high, x increments; at H_TOTAL-1 it wraps to 0.
  - On wrap, y increments; at V_TOTAL-1, y wraps to 0.
  - x, y and de are registered and change only on the clock following pix_stb; they hold otherwise.
- Region FSM per axis, states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE:
  - Transition on counter reaching the region end: H_ACTIVE, +H_FP, +H_SYNC, and wrap.
  - Vertical FSM advances only on horizontal wrap.
  - Reset state is ACTIVE.
- Raw sync: asserted while the axis FSM is in SYNC.
  - Horizontal: x in [656, 751].
  - Vertical: y in [490, 491].
- Sync delay:
  - Raw hsync/vsync pass through a SYNC_DELAY-deep clk shift register before reaching the ports.
  - SYNC_DELAY = 0 means a direct registered output aligned with x/y.
- de: combinational AND of both FSMs in ACTIVE, registered together with x/y.
- line_tick: high for exactly the one clk on which x becomes 0.
- frame_tick: high for exactly the one clk on which (x, y) becomes (0, V_ACTIVE). Game logic updates during blanking.
- Zero-width regions (e.g. H_FP = 0): the FSM skips that state in the same strobe; no extra pixel is inserted.
- rst asserted mid-frame: all outputs return to reset values immediately (async), and counting restarts from (0, 0) after release. No tick is emitted by the reset itself.

Decomposition:
- Package vga_pkg:
  - 640x480@60 timing localparams.
  - H_TOTAL/V_TOTAL functions.
  - Region state enum {ACTIVE, FRONT, SYNC, BACK}.
- One sub-module, vga_axis_counter, is natural:
  - Parameterised counter plus region FSM.
  - Inputs: advance enable. Outputs: count, in_active, in_sync, wrap.
  - Instantiated once for the horizontal axis (enable = pix_stb) and once for the vertical axis (enable = horizontal wrap & pix_stb).

Test Plan:
- Reset/strobe: hold rst 5 clks, release. Required:
  - All outputs at reset values.
  - pix_stb first high on clk 4 after release, then every 4 clks.
  - x = 1 appears one clk after the first pix_stb.
- Horizontal timing, defaults: over one line, de high for exactly 640 strobes (with y < 480) and hsync = 0 for exactly 96 strobes, starting when x = 656. line_tick fires once per 800 strobes.
- Frame: run 420000 strobes. Required:
  - Exactly 307200 strobes with de high.
  - vsync = 0 for 1600 strobes (y = 490..491).
  - frame_tick exactly once, coincident with x = 0, y = 480.
- Sync alignment: with SYNC_DELAY = 1, the hsync falling edge occurs exactly 1 clk after x changes to 656. With SYNC_DELAY = 3, it occurs 3 clks after.
- Small config for fast sim: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=0, V_SYNC=1, V_BP=1, CLK_DIV=2. Check the full x/y/de/hsync/vsync sequence over 2 frames against a reference model, including the zero-width V_FP skip.
- Mid-frame reset: assert rst at x=300, y=200 for 1 clk, asynchronously between edges. Required:
  - Outputs reset immediately.
  - After release, the sequence restarts at (0, 0).
  - No spurious line_tick or frame_tick.
